sumsq_acc: RTL

Parametrised, streaming sum-of-squares engine: computes Σ xᵢ² over NCH input channels per sample and optionally accumulates the result over a programmable frame, producing signal energy. It sits in the DSP datapath after the sample front-end, feeding the word-length analysis and control logic. It replaces the fixed two-channel squarer with valid/ready flow control, signed/unsigned inputs, and saturating output.

---
 rtl/sumsq_pkg.sv | 37 +++
 rtl/sumsq_acc_if.sv | 38 +++
 rtl/sumsq_tree.sv | 37 +++
 rtl/sumsq_acc.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/sumsq_pkg.sv
// Shared types and width helpers for the sum-of-squares engine.
package sumsq_pkg;

  typedef enum logic {
    MODE_INST  = 1'b0,
    MODE_FRAME = 1'b1
  } sumsq_mode_e;

  // Widest accumulator the saturation helper can handle.
  localparam int unsigned SAT_W = 64;

  // Width of one squared channel sample.
  function automatic int unsigned sq_w(input int unsigned in_w);
    return 2 * in_w;
  endfunction

  // Width of the sum of nch squares, sized so no carry is ever lost.
  function automatic int unsigned sum_w(input int unsigned in_w, input int unsigned nch);
    return sq_w(in_w) + $clog2(nch);
  endfunction

  // Width of the frame accumulator: one sum per sample, up to 2^cnt_w samples.
  function automatic int unsigned acc_w(input int unsigned in_w, input int unsigned nch,
                                        input int unsigned cnt_w);
    return sum_w(in_w, nch) + cnt_w;
  endfunction

  // Clamp an unsigned value to the largest out_w-bit unsigned number.
  function automatic logic [SAT_W-1:0] sat_u(input logic [SAT_W-1:0] value,
                                             input int unsigned out_w);
    logic [SAT_W-1:0] lim;
    if (out_w >= SAT_W) return value;
    lim = (SAT_W'(1) << out_w) - SAT_W'(1);
    return (value > lim) ? lim : value;
  endfunction

endpackage

// File: rtl/sumsq_acc_if.sv
// Sample-in / result-out bus of the sum-of-squares engine.
//
// Handshake: both channels use valid/ready. A word transfers on a rising clk
// edge where valid and ready are both high. A source holding valid high keeps
// its data stable until that transfer; ready may depend combinationally on the
// consumer's state but never on valid of the same channel.
interface sumsq_acc_if
  import sumsq_pkg::*;
#(
  parameter int NCH   = 2,
  parameter int IN_W  = 12,
  parameter int OUT_W = 22,
  parameter int CNT_W = 8
) ();

  sumsq_mode_e           mode;
  logic [CNT_W-1:0]      frame_len;
  logic                  in_valid;
  logic                  in_ready;
  logic [NCH*IN_W-1:0]   in_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [OUT_W-1:0]      out_data;
  logic                  out_sat;

  // Sample producer / result consumer side.
  modport master (
    output mode, frame_len, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_sat
  );

  // Engine side.
  modport slave (
    input  mode, frame_len, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_sat
  );

endinterface

// File: rtl/sumsq_tree.sv
// Registered N-input adder tree with valid tracking and a pipeline enable.
module sumsq_tree #(
  parameter int N     = 2,
  parameter int IN_W  = 24,
  parameter int OUT_W = 25
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              en,
  input  logic              valid_in,
  input  logic [N*IN_W-1:0] data_in,
  output logic              valid_out,
  output logic [OUT_W-1:0]  sum
);

  logic [OUT_W-1:0] total;

  // Add all operands at full output width; synthesis balances the chain.
  always_comb begin
    total = '0;
    for (int i = 0; i < N; i++) begin
      total = total + OUT_W'(data_in[i*IN_W +: IN_W]);
    end
  end

  // Register the sum; hold everything while the pipe is stalled.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      valid_out <= 1'b0;
      sum       <= '0;
    end else if (en) begin
      valid_out <= valid_in;
      if (valid_in) sum <= total;
    end
  end

endmodule

// File: rtl/sumsq_acc.sv
// Streaming sum-of-squares engine: squares each channel, sums the channels,
// optionally accumulates over a frame and emits a saturated unsigned result.
// Pipeline: square -> adder tree -> accumulate -> output register.
module sumsq_acc
  import sumsq_pkg::*;
#(
  parameter int NCH    = 2,
  parameter int IN_W   = 12,
  parameter int OUT_W  = 22,
  parameter int CNT_W  = 8,
  parameter int SIGNED = 0
) (
  input  logic        clk,
  input  logic        rstn,
  sumsq_acc_if.slave  bus
);

  localparam int SQ_W  = sq_w(IN_W);
  localparam int SUM_W = sum_w(IN_W, NCH);
  localparam int ACC_W = acc_w(IN_W, NCH, CNT_W);

  // Global stall: the output register is full and nobody is taking it.
  logic advance;
  logic accept;

  logic                out_valid_q;
  logic [OUT_W-1:0]    out_data_q;
  logic                out_sat_q;

  assign advance       = !out_valid_q || bus.out_ready;
  assign bus.in_ready  = advance && rstn;
  assign accept        = bus.in_valid && bus.in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_sat   = out_sat_q;

  // ---------------- stage 1: per-channel square ----------------
  logic [NCH*SQ_W-1:0] sq_d;
  logic [NCH*SQ_W-1:0] sq_q;
  logic                v1;

  for (genvar i = 0; i < NCH; i++) begin : g_sq
    if (SIGNED != 0) begin : g_signed
      logic signed [SQ_W-1:0] xe;
      assign xe = SQ_W'($signed(bus.in_data[i*IN_W +: IN_W]));
      assign sq_d[i*SQ_W +: SQ_W] = xe * xe;
    end else begin : g_unsigned
      logic [SQ_W-1:0] xe;
      assign xe = SQ_W'(bus.in_data[i*IN_W +: IN_W]);
      assign sq_d[i*SQ_W +: SQ_W] = xe * xe;
    end
  end

  // Capture squares of an accepted sample; a bubble only clears v1.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      v1   <= 1'b0;
      sq_q <= '0;
    end else if (advance) begin
      v1 <= accept;
      if (accept) sq_q <= sq_d;
    end
  end

  // ---------------- stage 2: adder tree ----------------
  logic             v2;
  logic [SUM_W-1:0] sum2;

  sumsq_tree #(
    .N     (NCH),
    .IN_W  (SQ_W),
    .OUT_W (SUM_W)
  ) u_tree (
    .clk       (clk),
    .rstn      (rstn),
    .en        (advance),
    .valid_in  (v1),
    .data_in   (sq_q),
    .valid_out (v2),
    .sum       (sum2)
  );

  // ---------------- stage 3: frame accumulator ----------------
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] len_q;
  sumsq_mode_e      mode_q;
  logic [ACC_W-1:0] acc;
  logic             v3;

  logic             frame_start;
  logic [CNT_W-1:0] start_len;
  logic [CNT_W-1:0] eff_len;
  logic             last;
  logic [ACC_W-1:0] acc_next;

  // Mode and length are sampled only when a frame's first sample lands here,
  // so edits to them mid-frame wait for the next frame.
  assign frame_start = (cnt == '0);
  assign start_len   = (bus.mode == MODE_INST || bus.frame_len == '0) ? CNT_W'(1)
                                                                       : bus.frame_len;
  assign eff_len     = frame_start ? start_len
                                   : ((mode_q == MODE_INST) ? CNT_W'(1) : len_q);
  assign last        = ((CNT_W+1)'(cnt) + (CNT_W+1)'(1)) == (CNT_W+1)'(eff_len);
  assign acc_next    = (frame_start ? '0 : acc) + ACC_W'(sum2);

  // Accumulate each sum; flag the completed frame for the output register.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      cnt    <= '0;
      len_q  <= CNT_W'(1);
      mode_q <= MODE_INST;
      acc    <= '0;
      v3     <= 1'b0;
    end else if (advance) begin
      v3 <= 1'b0;
      if (v2) begin
        if (frame_start) begin
          mode_q <= bus.mode;
          len_q  <= start_len;
        end
        acc <= acc_next;
        if (last) begin
          cnt <= '0;
          v3  <= 1'b1;
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end
    end
  end

  // ---------------- output register with saturation ----------------
  logic [SAT_W-1:0] acc_ext;
  logic [SAT_W-1:0] acc_sat;

  assign acc_ext = SAT_W'(acc);
  assign acc_sat = sat_u(acc_ext, OUT_W);

  // Load a finished frame; otherwise empty the register once it was taken.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sat_q   <= 1'b0;
    end else if (advance) begin
      out_valid_q <= v3;
      if (v3) begin
        out_data_q <= acc_sat[OUT_W-1:0];
        out_sat_q  <= (acc_sat != acc_ext);
      end
    end
  end

endmodule
